// File: rtl/adel_imem_loader.sv
// Instruction memory plus length-prefixed, XOR-checksummed byte-stream loader for the adel core.
// Holds the core in reset while a program is streamed in; in RUN serves inst = mem[pc] combinationally.
module adel_imem_loader #(
    parameter int IW = 16,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          prog_start,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    output logic          ld_ready,
    input  logic [AW-1:0] pc,
    output logic [IW-1:0] inst,
    output logic          core_nrst,
    output logic          busy,
    output logic          err
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_LO   = 3'd2,
        ST_HI   = 3'd3,
        ST_CSUM = 3'd4,
        ST_RUN  = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [AW:0]   rem_q, rem_d;
    logic [7:0]    csum_q, csum_d;
    logic [7:0]    lo_q, lo_d;
    logic          err_q, err_d;
    logic          core_nrst_q, core_nrst_d;

    logic [IW-1:0] mem [DEPTH];

    logic          accept;
    logic          wr_en;

    always_comb begin
        ld_ready = 1'b0;
        case (state_q)
            ST_LEN, ST_LO, ST_HI, ST_CSUM: ld_ready = 1'b1;
            default:                       ld_ready = 1'b0;
        endcase
    end

    assign busy   = ld_ready;
    assign accept = ld_valid && ld_ready;
    // prog_start overrides a byte arriving on the same edge, so the write is suppressed too.
    assign wr_en  = accept && !prog_start && (state_q == ST_HI);

    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        rem_d   = rem_q;
        csum_d  = csum_q;
        lo_d    = lo_q;
        err_d   = err_q;

        if (prog_start) begin
            state_d = ST_LEN;
            err_d   = 1'b0;
        end else if (accept) begin
            case (state_q)
                ST_LEN: begin
                    rem_d   = (ld_data == 8'd0) ? (AW+1)'(DEPTH) : (AW+1)'(ld_data);
                    waddr_d = '0;
                    csum_d  = ld_data;
                    state_d = ST_LO;
                end
                ST_LO: begin
                    lo_d    = ld_data;
                    csum_d  = csum_q ^ ld_data;
                    state_d = ST_HI;
                end
                ST_HI: begin
                    csum_d  = csum_q ^ ld_data;
                    waddr_d = waddr_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                    state_d = (rem_q == (AW+1)'(1)) ? ST_CSUM : ST_LO;
                end
                ST_CSUM: begin
                    if (ld_data == csum_q) begin
                        state_d = ST_RUN;
                        err_d   = 1'b0;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
                default: state_d = state_q;
            endcase
        end

        core_nrst_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            waddr_q     <= '0;
            rem_q       <= '0;
            csum_q      <= '0;
            lo_q        <= '0;
            err_q       <= 1'b0;
            core_nrst_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            waddr_q     <= waddr_d;
            rem_q       <= rem_d;
            csum_q      <= csum_d;
            lo_q        <= lo_d;
            err_q       <= err_d;
            core_nrst_q <= core_nrst_d;
        end
    end

    // Memory contents survive reset and aborted loads; only HI writes touch it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[waddr_q] <= {ld_data, lo_q};
        end
    end

    assign inst      = (state_q == ST_RUN) ? mem[pc] : '0;
    assign core_nrst = core_nrst_q;
    assign err       = err_q;

endmodule

// File: tb/tb_adel_imem_loader.sv
// Directed bench for adel_imem_loader: load, checksum error, 256-word load, abort, throttling, async reset.
module tb_adel_imem_loader;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        prog_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_data = 8'h00;
    logic        ld_ready;
    logic [7:0]  pc = 8'h00;
    logic [15:0] inst;
    logic        core_nrst;
    logic        busy;
    logic        err;

    int checks = 0;
    int fails  = 0;

    adel_imem_loader #(.IW(16), .AW(8)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .prog_start (prog_start),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .pc         (pc),
        .inst       (inst),
        .core_nrst  (core_nrst),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        check1("ld_ready_before_byte", ld_ready, 1'b1);
        ld_valid = 1'b1;
        ld_data  = b;
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
    endtask

    task automatic send_thr(input logic [7:0] b);
        @(negedge clk);
        ld_valid = 1'b0;
        ld_data  = 8'hFF;
        @(posedge clk);
        #1;
        send(b);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        prog_start = 1'b1;
        @(posedge clk);
        #1;
        prog_start = 1'b0;
    endtask

    task automatic read_at(input string tag, input logic [7:0] a, input logic [15:0] exp);
        pc = a;
        #1;
        check16(tag, inst, exp);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check1("rst_ld_ready", ld_ready, 1'b0);
        check1("rst_core_nrst", core_nrst, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_err", err, 1'b0);
        check16("rst_inst", inst, 16'h0000);
        @(negedge clk);
        nrst = 1'b1;

        // Bytes offered in IDLE are ignored
        ld_valid = 1'b1;
        ld_data  = 8'h02;
        repeat (3) @(posedge clk);
        #1;
        ld_valid = 1'b0;
        check1("idle_busy", busy, 1'b0);
        check1("idle_ld_ready", ld_ready, 1'b0);

        // Basic two-word load: 02 ^ 34 ^ 12 ^ 78 ^ 56 = 0A
        pulse_start();
        check1("t1_busy", busy, 1'b1);
        send(8'h02); send(8'h34); send(8'h12); send(8'h78); send(8'h56);
        check1("t1_pre_csum_core_nrst", core_nrst, 1'b0);
        send(8'h0A);
        check1("t1_core_nrst", core_nrst, 1'b1);
        check1("t1_busy_run", busy, 1'b0);
        check1("t1_err", err, 1'b0);
        check1("t1_ld_ready_run", ld_ready, 1'b0);
        read_at("t1_mem0", 8'h00, 16'h1234);
        read_at("t1_mem1", 8'h01, 16'h5678);

        // Bytes offered in RUN are ignored
        @(negedge clk);
        ld_valid = 1'b1;
        ld_data  = 8'h77;
        repeat (3) @(posedge clk);
        #1;
        ld_valid = 1'b0;
        check1("run_busy", busy, 1'b0);
        check1("run_core_nrst", core_nrst, 1'b1);
        check16("run_inst_stable", inst, 16'h5678);

        // Bad checksum
        pulse_start();
        check1("t2_core_nrst_fall", core_nrst, 1'b0);
        check16("t2_inst_load", inst, 16'h0000);
        send(8'h02); send(8'h34); send(8'h12); send(8'h78); send(8'h56);
        send(8'h09);
        check1("t2_err", err, 1'b1);
        check1("t2_core_nrst", core_nrst, 1'b0);
        check1("t2_busy", busy, 1'b0);
        check16("t2_inst", inst, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        check1("t2_err_sticky", err, 1'b1);
        pulse_start();
        check1("t2_err_clear", err, 1'b0);
        check1("t2_busy_restart", busy, 1'b1);

        // LEN=0 means 256 words; word i = i*0x0101, all data bytes cancel in XOR
        send(8'h00);
        for (int i = 0; i < 256; i++) begin
            send(8'(i));
            send(8'(i));
        end
        send(8'h00);
        check1("t3_core_nrst", core_nrst, 1'b1);
        check1("t3_err", err, 1'b0);
        read_at("t3_memFF", 8'hFF, 16'hFFFF);
        read_at("t3_mem00", 8'h00, 16'h0000);
        read_at("t3_mem80", 8'h80, 16'h8080);

        // Abort after LO of word 1
        pulse_start();
        send(8'h02); send(8'hAA); send(8'h55); send(8'hBB);
        pulse_start();
        check1("t4_busy", busy, 1'b1);
        check1("t4_ld_ready", ld_ready, 1'b1);
        check1("t4_core_nrst", core_nrst, 1'b0);
        check16("t4_mem0_kept", dut.mem[0], 16'h55AA);
        check16("t4_mem1_untouched", dut.mem[1], 16'h0101);
        // prog_start and a byte on the same edge: the byte is dropped
        @(negedge clk);
        prog_start = 1'b1;
        ld_valid   = 1'b1;
        ld_data    = 8'h05;
        @(posedge clk);
        #1;
        prog_start = 1'b0;
        ld_valid   = 1'b0;
        // 01 ^ CC ^ 33 = FE
        send(8'h01); send(8'hCC); send(8'h33); send(8'hFE);
        check1("t4_core_nrst_run", core_nrst, 1'b1);
        read_at("t4_mem0", 8'h00, 16'h33CC);
        read_at("t4_mem1", 8'h01, 16'h0101);

        // Throttled stream, idle gaps carry junk data that must be ignored
        pulse_start();
        send_thr(8'h02); send_thr(8'h34); send_thr(8'h12);
        send_thr(8'h78); send_thr(8'h56); send_thr(8'h0A);
        check1("t5_core_nrst", core_nrst, 1'b1);
        check1("t5_err", err, 1'b0);
        read_at("t5_mem0", 8'h00, 16'h1234);
        read_at("t5_mem1", 8'h01, 16'h5678);
        read_at("t5_mem2", 8'h02, 16'h0202);

        // Asynchronous reset while in HI
        pulse_start();
        send(8'h02); send(8'h34);
        #2;
        nrst = 1'b0;
        #1;
        check1("t6_core_nrst", core_nrst, 1'b0);
        check1("t6_ld_ready", ld_ready, 1'b0);
        check1("t6_busy", busy, 1'b0);
        @(negedge clk);
        nrst     = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 8'h01;
        repeat (3) @(posedge clk);
        #1;
        ld_valid = 1'b0;
        check1("t6_idle_busy", busy, 1'b0);
        check1("t6_idle_ld_ready", ld_ready, 1'b0);
        check1("t6_idle_core_nrst", core_nrst, 1'b0);
        pulse_start();
        check1("t6_restart_busy", busy, 1'b1);
        // 01 ^ 11 ^ 22 = 32
        send(8'h01); send(8'h11); send(8'h22); send(8'h32);
        check1("t6_core_nrst_run", core_nrst, 1'b1);
        read_at("t6_mem0", 8'h00, 16'h2211);
        read_at("t6_mem1", 8'h01, 16'h5678);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
